count_sampler: RTL

COUNT_SAMPLER -- requirements
Module: count_sampler

---
 rtl/count_sampler_pkg.sv | 20 ++
 rtl/count_sampler_cnt_sync.sv | 25 ++
 rtl/count_sampler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/count_sampler_pkg.sv
// Shared definitions for the ripple-counter sampling blocks: FSM state
// encodings, the wrap counter width and the stability counter width.
package count_sampler_pkg;

  // Sampler tracking state: INIT until the first value is accepted, then TRACK.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Width of the saturating accepted-wrap counter.
  localparam int WRAP_CNT_W = 8;

  // Width of the stability counter; holds STABLE_CYCLES up to 15.
  localparam int STAB_W = 4;

  // Largest STABLE_CYCLES value the stability counter can represent.
  localparam int STABLE_MAX = (1 << STAB_W) - 1;

endpackage

// File: rtl/count_sampler_cnt_sync.sv
// Two-flop synchronizer for the asynchronous ripple-counter bits. Both
// stages are exposed so the sampler can see a change one edge before it
// lands in sync2.
module cnt_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] sync1,
  output logic [WIDTH-1:0] sync2
);

  // Two-stage metastability filter, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= cnt_in;
      sync2 <= sync1;
    end
  end

endmodule

// File: rtl/count_sampler.sv
// Samples an asynchronous ripple counter: synchronizes the raw bits, waits
// for them to settle for STABLE_CYCLES edges, then presents each new stable
// value with wrap/error flags through a valid/ready holding register.
module count_sampler
  import count_sampler_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  up,
  input  logic [WIDTH-1:0]      cnt_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_wrap,
  output logic                  out_err,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic                  ovf
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > STABLE_MAX) begin : g_bad_stable
    $error("count_sampler: STABLE_CYCLES must be in 1..15");
  end

  localparam logic [WIDTH-1:0]  CNT_MAX     = '1;
  localparam logic [WIDTH-1:0]  STEP_UP     = WIDTH'(1);
  localparam logic [WIDTH-1:0]  STEP_DN     = '1;
  localparam logic [STAB_W-1:0] STAB_SAT    = '1;
  // The accept edge is the one where the counter already shows
  // STABLE_CYCLES-1 unchanged edges and sync2 holds across this edge too.
  localparam logic [STAB_W-1:0] STAB_THRESH = STAB_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]  sync1;
  logic [WIDTH-1:0]  sync2;
  logic [STAB_W-1:0] stab_cnt;
  logic [WIDTH-1:0]  last_val;
  state_t            state;

  logic              held;
  logic              accept;
  logic [WIDTH-1:0]  delta;
  logic              step_ok;
  logic              wrap_hit;
  logic              err_hit;

  // Saturating increment for the accepted-wrap counter.
  function automatic logic [WRAP_CNT_W-1:0] sat_inc(input logic [WRAP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // True when the step from prev to cur crosses the counter's wrap point.
  function automatic logic crosses_wrap(input logic dir,
                                        input logic [WIDTH-1:0] prev,
                                        input logic [WIDTH-1:0] cur);
    if (dir) return (prev == CNT_MAX) && (cur == '0);
    else     return (prev == '0) && (cur == CNT_MAX);
  endfunction

  cnt_sync #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .cnt_in (cnt_in),
    .sync1  (sync1),
    .sync2  (sync2)
  );

  // Stability counter: cleared when sync2 is about to change, otherwise
  // counts unchanged edges and saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      stab_cnt <= '0;
    end else if (sync1 != sync2) begin
      stab_cnt <= '0;
    end else if (stab_cnt != STAB_SAT) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // Acceptance decision and wrap/error classification of the candidate.
  always_comb begin
    held     = (sync1 == sync2) && (stab_cnt >= STAB_THRESH);
    accept   = held && ((state == ST_INIT) || (sync2 != last_val));
    delta    = sync2 - last_val;
    step_ok  = (delta == (up ? STEP_UP : STEP_DN));
    wrap_hit = 1'b0;
    err_hit  = 1'b0;
    if (state == ST_TRACK) begin
      wrap_hit = step_ok && crosses_wrap(up, last_val, sync2);
      err_hit  = !step_ok;
    end
  end

  // Tracking FSM with the output holding register, wrap counter and
  // sticky overflow; an accept always wins over a plain transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      last_val   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_wrap   <= 1'b0;
      out_err    <= 1'b0;
      wrap_count <= '0;
      ovf        <= 1'b0;
    end else begin
      if (accept) begin
        state     <= ST_TRACK;
        last_val  <= sync2;
        out_valid <= 1'b1;
        out_data  <= sync2;
        out_wrap  <= wrap_hit;
        out_err   <= err_hit;
        if (wrap_hit) begin
          wrap_count <= sat_inc(wrap_count);
        end
        if (out_valid && !out_ready) begin
          ovf <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
